bc_match_ctrl: RTL

Match-level controller sitting above the Bulls & Cows game core. It sequences rounds by pulsing the core's reset between rounds, counts committed guesses, and forces the core's game_over input when the guess budget runs out. It also tallies round wins per player and declares the match winner at first-to-WINS_TO_MATCH.

---
 rtl/bc_pkg.sv | 19 +
 rtl/bc_match_ctrl_if.sv | 47 ++++
 rtl/bc_turn_timer.sv | 37 +++
 rtl/bc_match_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared types and encodings for the Bulls & Cows match controller.
package bc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        LAST_CHECK,
        ROUND_END,
        MATCH_OVER
    } ctrl_state_t;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/bc_match_ctrl_if.sv
// Handshake and status bundle between the match controller and its surroundings.
interface bc_match_ctrl_if;

    logic       start;
    logic       guess_commit;
    logic       guess_player;
    logic       p1_win;
    logic       p2_win;
    logic       core_reset;
    logic       game_over;
    logic [7:0] guesses;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] match_winner;
    logic       turn_timeout;

    modport master (
        output start,
        output guess_commit,
        output guess_player,
        output p1_win,
        output p2_win,
        input  core_reset,
        input  game_over,
        input  guesses,
        input  p1_score,
        input  p2_score,
        input  match_winner,
        input  turn_timeout
    );

    modport slave (
        input  start,
        input  guess_commit,
        input  guess_player,
        input  p1_win,
        input  p2_win,
        output core_reset,
        output game_over,
        output guesses,
        output p1_score,
        output p2_score,
        output match_winner,
        output turn_timeout
    );

endinterface

// File: rtl/bc_turn_timer.sv
// Per-turn down-counter: reloads to TICKS-1, counts down while enabled, flags zero.
module bc_turn_timer #(
    parameter int unsigned TICKS = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICKS - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = RELOAD;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

    // Load is not folded in here; the caller gives a counted commit priority.
    assign expire = enable && (count_q == '0);

endmodule

// File: rtl/bc_match_ctrl.sv
// Match controller above the Bulls & Cows core: round sequencing, guess budget, scoring.
// Define BC_TURN_TIMER_EN to add a per-turn forfeit timer.
module bc_match_ctrl
    import bc_pkg::*;
#(
    parameter int unsigned MAX_GUESSES   = 16,
    parameter int unsigned WINS_TO_MATCH = 3,
    parameter int unsigned WIN_WAIT      = 4,
    parameter int unsigned TURN_TICKS    = 50_000_000
) (
    input logic            clock,
    input logic            reset,
    bc_match_ctrl_if.slave bus
);

    localparam logic [7:0]        GUESS_LIMIT = 8'(MAX_GUESSES);
    localparam logic [3:0]        SCORE_LIMIT = 4'(WINS_TO_MATCH);
    localparam int unsigned       WAIT_W      = (WIN_WAIT > 1) ? $clog2(WIN_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(WIN_WAIT - 1);

    ctrl_state_t       state_q, state_d;
    logic [7:0]        guesses_q, guesses_d;
    logic [3:0]        p1_score_q, p1_score_d;
    logic [3:0]        p2_score_q, p2_score_d;
    logic [1:0]        winner_q, winner_d;
    logic              core_reset_q, core_reset_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              p1_q, p2_q;

    logic       p1_rise, p2_rise, win_rise;
    logic [7:0] guesses_inc;

    assign p1_rise     = bus.p1_win & ~p1_q;
    assign p2_rise     = bus.p2_win & ~p2_q;
    assign win_rise    = p1_rise | p2_rise;
    assign guesses_inc = guesses_q + 8'd1;

`ifdef BC_TURN_TIMER_EN
    logic turn_player_q;
    logic turn_timeout_q, turn_timeout_d;
    logic play_entry, commit_counted, timer_load, timer_expire;

    assign play_entry     = (state_d == PLAY) && (state_q != PLAY);
    assign commit_counted = (state_q == PLAY) && bus.guess_commit && !win_rise;
    assign timer_load     = play_entry || commit_counted;

    bc_turn_timer #(
        .TICKS (TURN_TICKS)
    ) u_turn_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (timer_load),
        .enable (state_q == PLAY),
        .expire (timer_expire)
    );

    // The player whose turn it is becomes the opponent of whoever just committed.
    always_ff @(posedge clock) begin
        if (reset) begin
            turn_player_q  <= P1;
            turn_timeout_q <= 1'b0;
        end else begin
            turn_timeout_q <= turn_timeout_d;
            if (play_entry) begin
                turn_player_q <= P1;
            end else if (commit_counted) begin
                turn_player_q <= ~bus.guess_player;
            end
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        guesses_d    = guesses_q;
        p1_score_d   = p1_score_q;
        p2_score_d   = p2_score_q;
        winner_d     = winner_q;
        core_reset_d = 1'b0;
        wait_d       = wait_q;
`ifdef BC_TURN_TIMER_EN
        turn_timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE, MATCH_OVER: begin
                if (bus.start) begin
                    state_d      = PLAY;
                    core_reset_d = 1'b1;
                    guesses_d    = '0;
                    p1_score_d   = '0;
                    p2_score_d   = '0;
                    winner_d     = WIN_NONE;
                end
            end
            PLAY: begin
                // A win rise outranks a commit in the same cycle; P1 outranks P2.
                if (p1_rise) begin
                    p1_score_d = p1_score_q + 4'd1;
                    state_d    = ROUND_END;
                end else if (p2_rise) begin
                    p2_score_d = p2_score_q + 4'd1;
                    state_d    = ROUND_END;
                end else if (bus.guess_commit) begin
                    guesses_d = guesses_inc;
                    if (guesses_inc == GUESS_LIMIT) begin
                        state_d = LAST_CHECK;
                        wait_d  = '0;
                    end
`ifdef BC_TURN_TIMER_EN
                end else if (timer_expire) begin
                    turn_timeout_d = 1'b1;
                    state_d        = ROUND_END;
                    if (turn_player_q == P1) begin
                        p2_score_d = p2_score_q + 4'd1;
                    end else begin
                        p1_score_d = p1_score_q + 4'd1;
                    end
`endif
                end
            end
            LAST_CHECK: begin
                if (p1_rise) begin
                    p1_score_d = p1_score_q + 4'd1;
                    state_d    = ROUND_END;
                end else if (p2_rise) begin
                    p2_score_d = p2_score_q + 4'd1;
                    state_d    = ROUND_END;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ROUND_END;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ROUND_END: begin
                if (p1_score_q == SCORE_LIMIT) begin
                    state_d  = MATCH_OVER;
                    winner_d = WIN_P1;
                end else if (p2_score_q == SCORE_LIMIT) begin
                    state_d  = MATCH_OVER;
                    winner_d = WIN_P2;
                end else if (bus.start) begin
                    state_d      = PLAY;
                    core_reset_d = 1'b1;
                    guesses_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            guesses_q    <= '0;
            p1_score_q   <= '0;
            p2_score_q   <= '0;
            winner_q     <= WIN_NONE;
            core_reset_q <= 1'b0;
            wait_q       <= '0;
            p1_q         <= 1'b0;
            p2_q         <= 1'b0;
        end else begin
            guesses_q    <= guesses_d;
            p1_score_q   <= p1_score_d;
            p2_score_q   <= p2_score_d;
            winner_q     <= winner_d;
            core_reset_q <= core_reset_d;
            wait_q       <= wait_d;
            p1_q         <= bus.p1_win;
            p2_q         <= bus.p2_win;
        end
    end

    always_comb begin
        bus.core_reset   = core_reset_q;
        bus.game_over    = (state_q == ROUND_END) || (state_q == MATCH_OVER);
        bus.guesses      = guesses_q;
        bus.p1_score     = p1_score_q;
        bus.p2_score     = p2_score_q;
        bus.match_winner = winner_q;
`ifdef BC_TURN_TIMER_EN
        bus.turn_timeout = turn_timeout_q;
`else
        bus.turn_timeout = 1'b0;
`endif
    end

endmodule
